// File: rtl/text_video_pkg.sv
// Shared types and constants for the character-cell video generator:
// FSM encoding, default raster totals, control codes, blink period and the
// built-in 8x16 font table used by the glyph ROM.
package text_video_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } fsm_t;

    // Default 640x480 raster geometry (phi cycles / lines)
    localparam int H_ACT_DEF  = 640;
    localparam int H_FP_DEF   = 16;
    localparam int H_SYNC_DEF = 96;
    localparam int H_BP_DEF   = 48;
    localparam int V_ACT_DEF  = 480;
    localparam int V_FP_DEF   = 10;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BP_DEF   = 33;

    localparam int H_TOTAL = H_ACT_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL = V_ACT_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Control / fill codes (compared after truncation to the character width)
    localparam logic [7:0] NL_CODE    = 8'h0A;
    localparam logic [7:0] SPACE_CODE = 8'h20;

    // Cursor blink toggles once per this many frames
    localparam int BLINK_FRAMES = 32;

    // Font row lookup, MSB is the leftmost pixel. 'A' and 'B' carry real
    // glyphs, space is blank, every other code shows its own value as a bar
    // pattern on rows 2..13 so that unexpected codes are visible on screen.
    function automatic logic [7:0] font_row(input logic [7:0] code, input logic [3:0] row);
        logic [7:0] bits;
        bits = 8'h00;
        case (code)
            8'h41: begin
                case (row)
                    4'd2:    bits = 8'h10;
                    4'd3:    bits = 8'h38;
                    4'd4:    bits = 8'h6C;
                    4'd5:    bits = 8'hC6;
                    4'd6:    bits = 8'hC6;
                    4'd7:    bits = 8'hFE;
                    4'd8:    bits = 8'hC6;
                    4'd9:    bits = 8'hC6;
                    4'd10:   bits = 8'hC6;
                    4'd11:   bits = 8'hC6;
                    default: bits = 8'h00;
                endcase
            end
            8'h42: begin
                case (row)
                    4'd2:    bits = 8'hFC;
                    4'd3:    bits = 8'h66;
                    4'd4:    bits = 8'h66;
                    4'd5:    bits = 8'h66;
                    4'd6:    bits = 8'h7C;
                    4'd7:    bits = 8'h66;
                    4'd8:    bits = 8'h66;
                    4'd9:    bits = 8'h66;
                    4'd10:   bits = 8'h66;
                    4'd11:   bits = 8'hFC;
                    default: bits = 8'h00;
                endcase
            end
            8'h20: bits = 8'h00;
            default: begin
                if ((row >= 4'd2) && (row <= 4'd13)) begin
                    bits = {1'b0, code[6:0]};
                end else begin
                    bits = 8'h00;
                end
            end
        endcase
        return bits;
    endfunction

endpackage

// File: rtl/text_video_gen_glyph_rom.sv
// Synchronous glyph ROM: one registered row of GLYPH_W pixels per
// (code, glyph row) address. Contents come from the package font table.
module glyph_rom #(
    parameter int CHAR_W  = 7,
    parameter int GLYPH_W = 8,
    parameter int GLYPH_H = 16
) (
    input  logic                       clk_i,
    input  logic [CHAR_W-1:0]          code_i,
    input  logic [$clog2(GLYPH_H)-1:0] row_i,
    output logic [GLYPH_W-1:0]         data_o
);
    import text_video_pkg::*;

    logic [GLYPH_W-1:0] data_q;

    // Registered ROM read; the output register is the second pixel stage
    always_ff @(posedge clk_i) begin
        data_q <= GLYPH_W'(font_row(8'(code_i), 4'(row_i)));
    end

    assign data_o = data_q;

endmodule

// File: rtl/text_video_gen.sv
// Character-cell video generator: accepts a character stream into a text
// buffer (with newline handling and a post-reset clear) and renders the
// buffer through the glyph ROM to a 12-bit RGB output with hsync/vsync.
// Pixel path latency is two phi cycles from the raster counters.
// Optional build macro: CURSOR_BLINK_EN -- when defined the cell under the
// write cursor is drawn as a solid foreground block on alternate 32-frame
// periods while the block is in RUN.
module text_video_gen #(
    parameter int          CHAR_W   = 7,
    parameter int          COLS     = 80,
    parameter int          ROWS     = 30,
    parameter int          GLYPH_W  = 8,
    parameter int          GLYPH_H  = 16,
    parameter int          H_ACT    = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_ACT    = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0,
    parameter logic [11:0] FG_RGB   = 12'hFFF,
    parameter logic [11:0] BG_RGB   = 12'h000
) (
    input  logic                    phi,
    input  logic                    rst,
    input  logic [CHAR_W-1:0]       charsel,
    input  logic                    valid,
    output logic                    ready,
    output logic [$clog2(COLS)-1:0] wrcol,
    output logic [11:0]             dac_vid,
    output logic                    hsync,
    output logic                    vsync
);
    import text_video_pkg::*;

    localparam int HT     = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int VT     = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int HC_W   = $clog2(HT);
    localparam int VC_W   = $clog2(VT);
    localparam int NCELL  = COLS * ROWS;
    localparam int ADDR_W = $clog2(NCELL);
    localparam int COL_W  = $clog2(COLS);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int GX_W   = $clog2(GLYPH_W);
    localparam int GY_W   = $clog2(GLYPH_H);

    // Raster counters
    logic [HC_W-1:0] hcnt_q, hcnt_d;
    logic [VC_W-1:0] vcnt_q, vcnt_d;

    // Write-side FSM and cursor
    fsm_t              state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              ready_q, ready_d;
    logic [ROW_W-1:0]  next_row_s;
    logic              we_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [CHAR_W-1:0] wr_data_s;

    // Text buffer and pixel pipeline
    logic [CHAR_W-1:0]  mem_q [NCELL];
    logic [CHAR_W-1:0]  code_q;
    logic               act0_s, hs0_s, vs0_s;
    logic [COL_W-1:0]   cell_col_s;
    logic [ROW_W-1:0]   cell_row_s;
    logic [ADDR_W-1:0]  rd_addr_s;
    logic [GX_W-1:0]    gx0_s, gx1_q, gx2_q;
    logic [GY_W-1:0]    gy0_s, gy1_q;
    logic               act1_q, hs1_q, vs1_q;
    logic               act2_q, hs2_q, vs2_q;
    logic [GLYPH_W-1:0] rom_data_s;
    logic [GX_W-1:0]    bit_idx_s;
    logic               pix_s, fg_s;

    // Raster next-state: horizontal wrap advances the line, last line wraps
    always_comb begin
        hcnt_d = hcnt_q + HC_W'(1);
        vcnt_d = vcnt_q;
        if (hcnt_q == HC_W'(HT - 1)) begin
            hcnt_d = '0;
            if (vcnt_q == VC_W'(VT - 1)) begin
                vcnt_d = '0;
            end else begin
                vcnt_d = vcnt_q + VC_W'(1);
            end
        end else begin
            vcnt_d = vcnt_q;
        end
    end

    // Raster counter registers
    always_ff @(posedge phi) begin
        if (rst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign next_row_s = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);

    // Write FSM: CLEAR fills the buffer with spaces, RUN accepts characters
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        row_d      = row_q;
        col_d      = col_q;
        we_s       = 1'b0;
        wr_addr_s  = '0;
        wr_data_s  = CHAR_W'(SPACE_CODE);
        case (state_q)
            CLEAR: begin
                we_s      = 1'b1;
                wr_addr_s = clr_addr_q;
                if (clr_addr_q == ADDR_W'(NCELL - 1)) begin
                    state_d    = RUN;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_W'(1);
                end
            end
            RUN: begin
                if (valid && ready_q) begin
                    if (charsel == CHAR_W'(NL_CODE)) begin
                        col_d = '0;
                        row_d = next_row_s;
                    end else begin
                        we_s      = 1'b1;
                        wr_addr_s = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);
                        wr_data_s = charsel;
                        if (col_q == COL_W'(COLS - 1)) begin
                            col_d = '0;
                            row_d = next_row_s;
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end
                end else begin
                    col_d = col_q;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
        ready_d = (state_d == RUN);
    end

    // FSM, clear address, cursor and ready registers
    always_ff @(posedge phi) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            row_q      <= '0;
            col_q      <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            row_q      <= row_d;
            col_q      <= col_d;
            ready_q    <= ready_d;
        end
    end

    // Stage 0 decode: active area, sync windows and cell/glyph coordinates
    always_comb begin
        act0_s     = (hcnt_q < HC_W'(H_ACT)) && (vcnt_q < VC_W'(V_ACT));
        hs0_s      = ((hcnt_q >= HC_W'(H_ACT + H_FP)) && (hcnt_q < HC_W'(H_ACT + H_FP + H_SYNC)))
                     ? SYNC_POL : !SYNC_POL;
        vs0_s      = ((vcnt_q >= VC_W'(V_ACT + V_FP)) && (vcnt_q < VC_W'(V_ACT + V_FP + V_SYNC)))
                     ? SYNC_POL : !SYNC_POL;
        cell_col_s = COL_W'(hcnt_q / HC_W'(GLYPH_W));
        cell_row_s = ROW_W'(vcnt_q / VC_W'(GLYPH_H));
        gx0_s      = GX_W'(hcnt_q % HC_W'(GLYPH_W));
        gy0_s      = GY_W'(vcnt_q % VC_W'(GLYPH_H));
        if (act0_s) begin
            rd_addr_s = ADDR_W'(cell_row_s) * ADDR_W'(COLS) + ADDR_W'(cell_col_s);
        end else begin
            rd_addr_s = '0;
        end
    end

    // Text buffer: one write port, one registered read-first display port;
    // a write offered while rst is high is discarded
    always_ff @(posedge phi) begin
        if (we_s && !rst) begin
            mem_q[wr_addr_s] <= wr_data_s;
        end
        code_q <= mem_q[rd_addr_s];
    end

    // Stage 1 / stage 2 side-band delay so sync and blanking align with pixels
    always_ff @(posedge phi) begin
        if (rst) begin
            gx1_q  <= '0;
            gy1_q  <= '0;
            act1_q <= 1'b0;
            hs1_q  <= !SYNC_POL;
            vs1_q  <= !SYNC_POL;
            gx2_q  <= '0;
            act2_q <= 1'b0;
            hs2_q  <= !SYNC_POL;
            vs2_q  <= !SYNC_POL;
        end else begin
            gx1_q  <= gx0_s;
            gy1_q  <= gy0_s;
            act1_q <= act0_s;
            hs1_q  <= hs0_s;
            vs1_q  <= vs0_s;
            gx2_q  <= gx1_q;
            act2_q <= act1_q;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
        end
    end

    glyph_rom #(
        .CHAR_W  (CHAR_W),
        .GLYPH_W (GLYPH_W),
        .GLYPH_H (GLYPH_H)
    ) u_glyph_rom (
        .clk_i  (phi),
        .code_i (code_q),
        .row_i  (gy1_q),
        .data_o (rom_data_s)
    );

    assign bit_idx_s = GX_W'(GLYPH_W - 1) - gx2_q;
    assign pix_s     = rom_data_s[bit_idx_s];

`ifdef CURSOR_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_FRAMES);

    logic [BLINK_W-1:0] frame_q;
    logic               blink_q;
    logic               frame_end_s;
    logic               cur0_s, cur1_q, cur2_q;

    assign frame_end_s = (hcnt_q == HC_W'(HT - 1)) && (vcnt_q == VC_W'(VT - 1));
    assign cur0_s      = act0_s && (state_q == RUN) && blink_q &&
                         (cell_row_s == row_q) && (cell_col_s == col_q);

    // Frame counter: blink starts on and flips every BLINK_FRAMES frames
    always_ff @(posedge phi) begin
        if (rst) begin
            frame_q <= '0;
            blink_q <= 1'b1;
        end else if (frame_end_s) begin
            frame_q <= frame_q + BLINK_W'(1);
            if (frame_q == BLINK_W'(BLINK_FRAMES - 1)) begin
                blink_q <= !blink_q;
            end
        end
    end

    // Cursor-hit delay line matching the two pixel stages
    always_ff @(posedge phi) begin
        if (rst) begin
            cur1_q <= 1'b0;
            cur2_q <= 1'b0;
        end else begin
            cur1_q <= cur0_s;
            cur2_q <= cur1_q;
        end
    end

    assign fg_s = pix_s | cur2_q;
`else
    assign fg_s = pix_s;
`endif

    assign dac_vid = act2_q ? (fg_s ? FG_RGB : BG_RGB) : 12'h000;
    assign hsync   = hs2_q;
    assign vsync   = vs2_q;
    assign ready   = ready_q;
    assign wrcol   = col_q;

endmodule
